// File: rtl/pwm_channel_serializer.sv
// Purpose: per-channel PWM comparator whose result (or a brightness word) is snapshotted and shifted MSB-first to an LED driver chain.
// Latency: first bit appears the cycle after start; latch at T+2*CHANNELS, done at T+2*CHANNELS+1.
// Backpressure: none; start is honoured only when idle, and start while busy is dropped (not queued).
module pwm_channel_serializer #(
    parameter int CHANNELS    = 16,
    parameter int PWM_BITS    = 8,
    parameter int BRIGHT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         frame_sel,
    input  logic [PWM_BITS-1:0]          pwm_time,
    input  logic [CHANNELS*PWM_BITS-1:0] component_values,
    input  logic                         brightness_wr,
    input  logic [BRIGHT_BITS-1:0]       brightness_in,
    output logic                         serial_data_out,
    output logic                         serial_clk,
    output logic                         latch,
    output logic                         busy,
    output logic                         done
);

    // Counter must hold CHANNELS-1; keep it at least one bit wide for CHANNELS = 1.
    localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t                 state;
    logic                   phase;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CHANNELS-1:0]    shift_reg;
    logic [BRIGHT_BITS-1:0] brightness_reg;

    logic [CHANNELS-1:0]    cmp;
    logic [CHANNELS-1:0]    bright_word;
    logic [CHANNELS-1:0]    frame_word;
    logic [CHANNELS-1:0]    shifted;

    // Per-channel unsigned compare: output high while the timebase is below the channel value.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_cmp
            assign cmp[gi] = (pwm_time < component_values[gi*PWM_BITS +: PWM_BITS]);
        end
    endgenerate

    // Build the candidate frame word: brightness zero-extended into the LSBs, or the compare vector.
    always_comb begin
        bright_word                    = '0;
        bright_word[BRIGHT_BITS-1:0]   = brightness_reg;
        frame_word                     = frame_sel ? bright_word : cmp;
        shifted                        = shift_reg << 1;
    end

    // Brightness register: writable in any state; the frame in flight already holds its own copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            brightness_reg <= '1;
        end else if (brightness_wr) begin
            brightness_reg <= brightness_in;
        end
    end

    // Frame sequencer: snapshot on start, two cycles per bit (clock low then high), then latch and done pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            phase           <= 1'b0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            serial_data_out <= 1'b0;
            serial_clk      <= 1'b0;
            latch           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done  <= 1'b0;
                    latch <= 1'b0;
                    if (start) begin
                        shift_reg       <= frame_word;
                        serial_data_out <= frame_word[CHANNELS-1];
                        serial_clk      <= 1'b0;
                        phase           <= 1'b0;
                        bit_cnt         <= '0;
                        busy            <= 1'b1;
                        state           <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!phase) begin
                        // Data has been stable for a cycle; raise the bit clock.
                        phase      <= 1'b1;
                        serial_clk <= 1'b1;
                    end else begin
                        phase      <= 1'b0;
                        serial_clk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            serial_data_out <= 1'b0;
                            latch           <= 1'b1;
                            state           <= ST_LATCH;
                        end else begin
                            shift_reg       <= shifted;
                            serial_data_out <= shifted[CHANNELS-1];
                            bit_cnt         <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    latch <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state           <= ST_IDLE;
                    phase           <= 1'b0;
                    serial_clk      <= 1'b0;
                    serial_data_out <= 1'b0;
                    latch           <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                end
            endcase
        end
    end

endmodule
